registers_tx_block: RTL and testbench
=====================================

Name: registers_tx_block

Overview:
- Register-frame serializer; the transmit-direction counterpart of the register receive path.
- Accepts one register frame (address + data) on a simple-interface input and emits it as a byte stream on a tx simple interface.
- The byte stream carries an EOF flag and plugs directly into a tx_protocol source port (data/rdy/eof/ack).
- Used for register readback and echo to the host over the FT245/UART link.

Parameters:
- TX_DATA_WIDTH, 8, output byte width; must be 8.
- REG_ADDR_WIDTH, 8, register address width; multiple of 8.
- REG_DATA_WIDTH, 16, register data width; multiple of 8.
- SEND_HEADER, 0, 1 = prepend HEADER_BYTE to every frame.
- HEADER_BYTE, 8'hA5, marker byte sent first when SEND_HEADER=1.

Ports:
- clk  input  1  system clock (clk_100M domain).
- rst  input  1  asynchronous, active-low reset.
- register_addr  input  REG_ADDR_WIDTH  address of the frame to send.
- register_data  input  REG_DATA_WIDTH  data of the frame to send.
- register_rdy  input  1  source holds high while addr/data are valid.
- register_ack  output  1  one-cycle pulse: frame captured.
- tx_data  output  TX_DATA_WIDTH  current byte.
- tx_rdy  output  1  tx_data valid.
- tx_eof  output  1  high with the last byte of a frame.
- tx_ack  input  1  sink consumed the byte (transfer on tx_rdy && tx_ack at a clk edge).
- busy  output  1  frame in progress (state != IDLE).

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state IDLE, byte counter 0, capture registers 0. Reset mid-frame discards the frame; no partial-frame resume after release.
- Frame length: N = SEND_HEADER + REG_ADDR_WIDTH/8 + REG_DATA_WIDTH/8. With defaults N=3; with header N=4.
- Byte order within a frame:
  - HEADER_BYTE, if enabled.
  - Address bytes, LSB byte first.
  - Data bytes, LSB byte first.
- States:
  - IDLE:
    - If register_rdy=1 at a clk edge: latch addr/data into the shift register, set register_ack=1 for exactly one cycle, counter to 0.
    - Present byte 0 in the same edge: tx_rdy=1, tx_data=byte0, tx_eof=(N==1). Go to SEND.
  - SEND:
    - tx_rdy stays 1; tx_data and tx_eof stay stable until a transfer.
    - On transfer of a non-last byte: counter+1, next byte presented the following cycle. Throughput is 1 byte/clk when tx_ack is held high.
    - On transfer of the last byte (tx_eof=1): tx_rdy=0, tx_eof=0, go to IDLE.
- tx_ack while tx_rdy=0 is ignored.
- register_rdy while in SEND is ignored (not acked, not captured). The source must hold rdy until it sees register_ack.
- Latency:
  - register_rdy sampled in IDLE → tx_rdy high 1 cycle later (registered outputs).
  - Last transfer edge → IDLE; a new frame can be captured on the next edge, so 1 idle cycle between frames minimum.
- The source drops register_rdy one cycle after register_ack. Because N≥2 cycles elapse before IDLE, the same frame is never captured twice.
- busy = 1 from the capture edge through the last-byte transfer edge.
- Counter width: clog2(N) bits, no wrap beyond N-1. Outputs are never combinational from inputs.

Test Plan:
- Defaults; addr=0x3C, data=0xBEEF, tx_ack held 1 → bytes 3C, EF, BE on 3 consecutive cycles; tx_eof only on BE; register_ack one pulse; busy for 3 cycles.
- SEND_HEADER=1; addr=0x05, data=0x1234; tx_ack pulsed every 4th cycle → bytes A5, 05, 34, 12; each held stable until its ack; eof on 12.
- register_rdy held high continuously with a new frame presented after each ack → frames back-to-back with exactly 1 idle cycle between them; no duplicate frame.
- rst driven low after the 2nd byte of a frame, then released → outputs 0 immediately (asynchronous). The next frame 0x01/0x00FF emits 01, FF, 00 with no leftover bytes.
- tx_ack pulses while tx_rdy=0 in IDLE → no state change, no output activity.
- register_rdy asserted mid-SEND → no register_ack until the current frame's eof transfer; that frame is captured 1 cycle after eof.

Source files
------------

// File: rtl/registers_tx_block.sv
// registers_tx_block: serializes one register frame (address + data) into a byte stream with EOF.
// Ports:
//   clk            system clock
//   rst            asynchronous, active-low reset
//   register_addr  frame address, held by the source while register_rdy is high
//   register_data  frame data, held by the source while register_rdy is high
//   register_rdy   frame valid from the source
//   register_ack   one-cycle pulse on the cycle after a frame is captured
//   tx_data        current byte (optional header, address LSB-first, data LSB-first)
//   tx_rdy         tx_data valid
//   tx_eof         high together with the last byte of a frame
//   tx_ack         sink takes the byte; a transfer happens on tx_rdy && tx_ack at a clk edge
//   busy           frame in progress
module registers_tx_block #(
  parameter int TX_DATA_WIDTH = 8,
  parameter int REG_ADDR_WIDTH = 8,
  parameter int REG_DATA_WIDTH = 16,
  parameter int SEND_HEADER = 0,
  parameter logic [TX_DATA_WIDTH-1:0] HEADER_BYTE = 8'hA5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] register_addr,
  input  logic [REG_DATA_WIDTH-1:0] register_data,
  input  logic                      register_rdy,
  output logic                      register_ack,
  output logic [TX_DATA_WIDTH-1:0]  tx_data,
  output logic                      tx_rdy,
  output logic                      tx_eof,
  input  logic                      tx_ack,
  output logic                      busy
);
  localparam int N = SEND_HEADER + REG_ADDR_WIDTH / 8 + REG_DATA_WIDTH / 8;
  localparam int FW = N * TX_DATA_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] sh_q, sh_d, frame_w;
  logic [TX_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic tx_rdy_q, tx_rdy_d, tx_eof_q, tx_eof_d, ack_q, ack_d;
  // Byte 0 sits in the low bits so the frame leaves LSB-first by shifting right.
  if (SEND_HEADER != 0) begin : g_hdr
    assign frame_w = {register_data, register_addr, HEADER_BYTE};
  end else begin : g_nohdr
    assign frame_w = {register_data, register_addr};
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    tx_data_d = tx_data_q;
    tx_rdy_d = tx_rdy_q;
    tx_eof_d = tx_eof_q;
    ack_d = 1'b0;
    if (state_q == IDLE) begin
      if (register_rdy) begin
        state_d = SEND;
        cnt_d = '0;
        sh_d = frame_w >> TX_DATA_WIDTH;
        tx_data_d = frame_w[TX_DATA_WIDTH-1:0];
        tx_rdy_d = 1'b1;
        tx_eof_d = (N == 1);
        ack_d = 1'b1;
      end
    end else if (tx_ack) begin
      if (tx_eof_q) begin
        state_d = IDLE;
        cnt_d = '0;
        tx_rdy_d = 1'b0;
        tx_eof_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CW'(1);
        sh_d = sh_q >> TX_DATA_WIDTH;
        tx_data_d = sh_q[TX_DATA_WIDTH-1:0];
        // The byte being presented next is the last one when the one leaving now is N-2.
        tx_eof_d = (cnt_q == CW'(N - 2));
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      tx_data_q <= '0;
      tx_rdy_q <= 1'b0;
      tx_eof_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      tx_data_q <= tx_data_d;
      tx_rdy_q <= tx_rdy_d;
      tx_eof_q <= tx_eof_d;
      ack_q <= ack_d;
    end
  end
  assign register_ack = ack_q;
  assign tx_data = tx_data_q;
  assign tx_rdy = tx_rdy_q;
  assign tx_eof = tx_eof_q;
  assign busy = (state_q == SEND);
endmodule

// File: tb/tb_registers_tx_block.sv
// tb_registers_tx_block: table, random and corner-case checks of the register frame serializer.
module tb_registers_tx_block;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] addr = '0, txd;
  logic [15:0] data = '0;
  logic rdy = 1'b0, txa = 1'b0, ack, txr, txe, bsy;
  logic [7:0] addr_h = '0, txd_h;
  logic [15:0] data_h = '0;
  logic rdy_h = 1'b0, txa_h = 1'b0, ack_h, txr_h, txe_h, bsy_h;

  registers_tx_block dut (
    .clk(clk), .rst(rst), .register_addr(addr), .register_data(data), .register_rdy(rdy),
    .register_ack(ack), .tx_data(txd), .tx_rdy(txr), .tx_eof(txe), .tx_ack(txa), .busy(bsy));

  registers_tx_block #(.SEND_HEADER(1)) dut_h (
    .clk(clk), .rst(rst), .register_addr(addr_h), .register_data(data_h), .register_rdy(rdy_h),
    .register_ack(ack_h), .tx_data(txd_h), .tx_rdy(txr_h), .tx_eof(txe_h), .tx_ack(txa_h), .busy(bsy_h));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: byte i of a frame, from the byte-order rules with plain arithmetic.
  function automatic logic [7:0] model_byte(input logic [7:0] a, input logic [15:0] d, input int i);
    int v;
    v = (i == 0) ? int'(a) : (int'(d) / (1 << (8 * (i - 1)))) % 256;
    return 8'(v);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every acked frame queues its expected bytes; every transfer pops one.
  logic [7:0] exp_q[$], rx_q[$];
  int ack_cnt = 0, busy_cnt = 0, last_eof_edge = 0;
  logic p_txr = 0, p_xfer = 0, p_txe = 0, p_ack = 0;
  logic [7:0] p_txd = 0, p_addr = 0, b;
  logic [15:0] p_data = 0;
  always @(negedge clk) begin
    if (!rst) begin
      p_txr = 0; p_xfer = 0; p_ack = 0;
    end else begin
      if (ack) begin
        check("ack_pulse", p_ack, 0);
        ack_cnt++;
        for (int i = 0; i < 3; i++) exp_q.push_back(model_byte(p_addr, p_data, i));
      end
      check("busy_vs_rdy", bsy, txr);
      if (p_txr && !p_xfer && txr) begin
        check("hold_data", txd, p_txd);
        check("hold_eof", txe, p_txe);
      end
      if (bsy) busy_cnt++;
      if (txr && txa) begin
        if (exp_q.size() == 0) check("extra_byte", exp_q.size(), 1);
        else begin
          b = exp_q.pop_front();
          check("byte", txd, b);
          check("eof", txe, exp_q.size() == 0);
        end
        rx_q.push_back(txd);
        if (txe) last_eof_edge = cyc + 1;
      end
      p_txr = txr; p_xfer = txr && txa; p_txd = txd; p_txe = txe; p_ack = ack;
    end
    p_addr = addr; p_data = data;
  end

  task automatic send_frame(input logic [7:0] a, input logic [15:0] d, input int p);
    int k;
    ack_cnt = 0; busy_cnt = 0; rx_q.delete();
    addr = a; data = d; rdy = 1; txa = (p == 1);
    k = 0;
    while (!ack && k < 20) begin tick; k++; end
    rdy = 0;
    check("capture", ack, 1);
    k = 0;
    while (bsy && k < 100) begin txa = ((k + 1) % p == 0); tick; k++; end
    txa = 0;
    check("frame_done", bsy, 0);
    tick;
    check("ack_count", ack_cnt, 1);
    check("busy_cycles", busy_cnt, 3 * p);
  endtask

  task automatic check_rx(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    check("rx_len", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      check("rx_b0", rx_q[0], b0);
      check("rx_b1", rx_q[1], b1);
      check("rx_b2", rx_q[2], b2);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [15:0] d;
    int p;
    logic [7:0] b0, b1, b2;
  } vec_t;
  vec_t tbl[6];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, idx, ack_edge;
    logic [7:0] a, hold, saved;
    logic [15:0] d;
    logic [7:0] fa[3];
    logic [15:0] fd[3];
    logic [7:0] got[4], hexp[4];
    logic gote[4], r;
    int ae[3];
    tbl[0] = '{8'h3C, 16'hBEEF, 1, 8'h3C, 8'hEF, 8'hBE};
    tbl[1] = '{8'h00, 16'h0000, 2, 8'h00, 8'h00, 8'h00};
    tbl[2] = '{8'hFF, 16'hFFFF, 3, 8'hFF, 8'hFF, 8'hFF};
    tbl[3] = '{8'h01, 16'h00FF, 1, 8'h01, 8'hFF, 8'h00};
    tbl[4] = '{8'h5A, 16'hA55A, 4, 8'h5A, 8'h5A, 8'hA5};
    tbl[5] = '{8'h80, 16'h0102, 2, 8'h80, 8'h02, 8'h01};
    #2;
    check("rst_tx_rdy", txr, 0); check("rst_tx_eof", txe, 0); check("rst_tx_data", txd, 0);
    check("rst_ack", ack, 0); check("rst_busy", bsy, 0); check("rst_h_tx_rdy", txr_h, 0);
    tick; tick;
    rst = 1;
    tick;
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].a, tbl[i].d, tbl[i].p);
      check_rx(tbl[i].b0, tbl[i].b1, tbl[i].b2);
    end
    for (int i = 0; i < 25; i++) begin
      a = 8'($urandom); d = 16'($urandom);
      repeat ($urandom_range(0, 2)) tick;
      send_frame(a, d, int'($urandom_range(1, 3)));
      check_rx(model_byte(a, d, 0), model_byte(a, d, 1), model_byte(a, d, 2));
    end
    // Header variant: A5, 05, 34, 12 with an ack every 4th cycle.
    hexp[0] = 8'hA5; hexp[1] = 8'h05; hexp[2] = 8'h34; hexp[3] = 8'h12;
    addr_h = 8'h05; data_h = 16'h1234; rdy_h = 1;
    k = 0;
    while (!ack_h && k < 20) begin tick; k++; end
    rdy_h = 0;
    check("h_capture", ack_h, 1);
    check("h_first_rdy", txr_h, 1);
    check("h_first_byte", txd_h, 8'hA5);
    idx = 0; k = 0;
    while (idx < 4 && k < 60) begin
      txa_h = (k % 4 == 3);
      hold = txd_h; r = txr_h;
      if (r && txa_h) begin got[idx] = txd_h; gote[idx] = txe_h; idx++; end
      tick;
      if (r && !txa_h) check("h_hold", txd_h, hold);
      k++;
    end
    txa_h = 0;
    check("h_count", idx, 4);
    check("h_idle_after", txr_h, 0);
    check("h_busy_after", bsy_h, 0);
    for (int i = 0; i < idx; i++) begin
      check("h_byte", got[i], hexp[i]);
      check("h_eof", gote[i], i == 3);
    end
    // Back-to-back with register_rdy held high: one idle cycle between frames.
    fa[0] = 8'h11; fd[0] = 16'h2233; fa[1] = 8'h44; fd[1] = 16'h5566; fa[2] = 8'h77; fd[2] = 16'h8899;
    ack_cnt = 0; rx_q.delete();
    addr = fa[0]; data = fd[0]; rdy = 1; txa = 1; idx = 0; k = 0;
    while (idx < 3 && k < 40) begin
      tick; k++;
      if (ack) begin
        ae[idx] = cyc; idx++;
        if (idx < 3) begin addr = fa[idx]; data = fd[idx]; end else rdy = 0;
      end
    end
    rdy = 0;
    check("b2b_acks", idx, 3);
    if (idx == 3) begin
      check("b2b_gap1", ae[1] - ae[0], 4);
      check("b2b_gap2", ae[2] - ae[1], 4);
    end
    k = 0;
    while (bsy && k < 20) begin tick; k++; end
    repeat (3) tick;
    txa = 0;
    check("b2b_ack_total", ack_cnt, 3);
    check("b2b_rx_len", rx_q.size(), 9);
    check("b2b_left", exp_q.size(), 0);
    if (rx_q.size() == 9)
      for (int f = 0; f < 3; f++)
        for (int i = 0; i < 3; i++) check("b2b_byte", rx_q[3 * f + i], model_byte(fa[f], fd[f], i));
    // Reset after the second byte of a frame.
    rx_q.delete();
    addr = 8'h77; data = 16'h1122; rdy = 1; txa = 0; k = 0;
    while (!ack && k < 20) begin tick; k++; end
    rdy = 0; txa = 1;
    tick; tick;
    check("pre_rst_rdy", txr, 1);
    #2;
    rst = 0;
    exp_q.delete();
    #1;
    check("arst_tx_rdy", txr, 0); check("arst_tx_eof", txe, 0); check("arst_tx_data", txd, 0);
    check("arst_busy", bsy, 0); check("arst_ack", ack, 0);
    check("arst_rx_len", rx_q.size(), 2);
    txa = 0;
    tick; tick;
    rst = 1;
    tick;
    send_frame(8'h01, 16'h00FF, 1);
    check_rx(8'h01, 8'hFF, 8'h00);
    // tx_ack toggling while idle must not move anything.
    saved = txd;
    for (int i = 0; i < 6; i++) begin
      txa = (i % 2 == 0);
      tick;
      check("idle_tx_rdy", txr, 0); check("idle_tx_eof", txe, 0); check("idle_busy", bsy, 0);
      check("idle_ack", ack, 0); check("idle_tx_data", txd, saved);
    end
    txa = 0;
    check("idle_rx_len", rx_q.size(), 3);
    // register_rdy raised mid-frame: captured one edge after the eof transfer.
    ack_cnt = 0; rx_q.delete();
    addr = 8'hA1; data = 16'hB2C3; rdy = 1; k = 0;
    while (!ack && k < 20) begin tick; k++; end
    rdy = 0;
    tick;
    addr = 8'h44; data = 16'h5566; rdy = 1; k = 0; ack_edge = 0;
    while (!ack && k < 40) begin txa = (k % 2 == 1); tick; k++; end
    ack_edge = cyc;
    rdy = 0;
    check("mid_capture", ack, 1);
    check("mid_ack_after_eof", ack_edge - last_eof_edge, 1);
    check("mid_rx_before", rx_q.size(), 3);
    txa = 1; k = 0;
    while (bsy && k < 20) begin tick; k++; end
    txa = 0;
    tick;
    check("mid_ack_total", ack_cnt, 2);
    check("mid_rx_len", rx_q.size(), 6);
    if (rx_q.size() == 6)
      for (int i = 0; i < 3; i++) begin
        check("mid_byte_a", rx_q[i], model_byte(8'hA1, 16'hB2C3, i));
        check("mid_byte_b", rx_q[3 + i], model_byte(8'h44, 16'h5566, i));
      end
    check("final_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
